write_decoder_pipe: RTL and testbench
=====================================

WRITE_DECODER_PIPE -- requirements
Module: write_decoder_pipe

Parameters
REQ-001 SHALL provide parameters: ADDR_W, default 5, register-address width.
REQ-002 SHALL provide parameters: ZERO_REG, default 31, hard-wired zero register index; writes to it are suppressed.
REQ-003 SHALL provide parameters: CNT_W, default 8, conflict-counter width.
REQ-004 SHALL derive NREG = 2**ADDR_W; ZERO_REG SHALL lie in 0..NREG-1.

Interface
REQ-005 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have ports: reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-007 SHALL have ports: wrA  input  1  channel A write request.
REQ-008 SHALL have ports: addrA  input  ADDR_W  channel A destination register.
REQ-009 SHALL have ports: wrB  input  1  channel B write request (younger, higher priority).
REQ-010 SHALL have ports: addrB  input  ADDR_W  channel B destination register.
REQ-011 SHALL have ports: stall  input  1  hold pipeline register, ignore inputs.
REQ-012 SHALL have ports: enable  output  NREG  registered per-register write enable.
REQ-013 SHALL have ports: srcB  output  NREG  per-register data select, 1 = take channel B data.
REQ-014 SHALL have ports: conflict  output  1  registered flag, both channels targeted same non-zero register.
REQ-015 SHALL have ports: conflictCnt  output  CNT_W  saturating count of conflicts.

Function
REQ-016 SHALL compute, combinationally, decA = one-hot(addrA) when wrA=1 and addrA!=ZERO_REG, else all zeros; decB likewise for channel B.
REQ-017 SHALL load enable <= decA | decB on each rising edge with stall=0; latency exactly 1 cycle from request to enable.
REQ-018 SHALL load srcB <= decB under the same condition, so srcB[i]=1 only where enable[i]=1 and channel B is the writer.
REQ-019 SHALL, when decA and decB select the same register, set exactly one enable bit with srcB at that bit =1 (channel B wins).
REQ-020 SHALL register conflict <= 1 for exactly that cycle under REQ-019's condition, else 0.
REQ-021 SHALL increment conflictCnt by 1 per conflict cycle, saturating at 2**CNT_W-1 without wrap-around.
REQ-022 SHALL, with stall=1 at a rising edge, hold enable, srcB and conflictCnt unchanged, force conflict <= 0, and discard inputs (no buffering).
REQ-023 SHALL treat any wr request to ZERO_REG as a no-op: no enable bit, no conflict, no count, including when both channels target ZERO_REG.
REQ-024 SHALL permit two distinct non-zero targets in one cycle: two enable bits set, srcB set only at addrB's bit.
REQ-025 SHALL never set more than two enable bits; with one request, exactly one; with none, zero.
REQ-026 SHALL have no combinational path from any input to any output.

Reset
REQ-027 SHALL, while reset=0, force enable=0, srcB=0, conflict=0, conflictCnt=0 asynchronously, independent of clk.
REQ-028 SHALL, on reset asserted mid-operation, including during stall, drop any in-flight decode; the first edge after reset=1 decodes fresh inputs.

Verification (ADDR_W=5, ZERO_REG=31, CNT_W=2)
REQ-029 SHALL cover: reset=0, wrA=wrB=1, addrA=3 -> enable=0, srcB=0, conflictCnt=0 throughout; release, next edge -> enable=0x00000008.
REQ-030 SHALL cover: wrA=1 addrA=5, wrB=1 addrB=9 -> after 1 edge enable=0x00000220, srcB=0x00000200, conflict=0.
REQ-031 SHALL cover: wrA=wrB=1, addrA=addrB=7 for 4 consecutive edges -> enable=0x00000080, srcB=0x00000080, conflict=1 each cycle, conflictCnt 1,2,3,3 (saturates).
REQ-032 SHALL cover: wrA=1 addrA=31, wrB=1 addrB=31 -> enable=0, conflict=0, conflictCnt unchanged.
REQ-033 SHALL cover: enable=0x00000004 held, stall=1 with wrB=1 addrB=12 for 2 edges -> enable stays 0x00000004; stall=0 with wrA=0, wrB=0 -> enable=0.
REQ-034 SHALL cover: reset pulsed low between edges while enable nonzero -> enable, srcB, conflictCnt =0 before the next clk edge.

Source files
------------

// File: rtl/write_decoder_pipe.sv
// Register-file write decoder: two write channels are decoded to per-register
// one-hot enables and registered with one cycle of latency. Channel B is the
// younger write and wins when both channels hit the same register. Writes to
// the hard-wired zero register are dropped. Same-register collisions are
// flagged for one cycle and tallied in a saturating counter.
module write_decoder_pipe #(
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 8,
  localparam int NREG    = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrA,
  input  logic [ADDR_W-1:0] addrA,
  input  logic              wrB,
  input  logic [ADDR_W-1:0] addrB,
  input  logic              stall,
  output logic [NREG-1:0]   enable,
  output logic [NREG-1:0]   srcB,
  output logic              conflict,
  output logic [CNT_W-1:0]  conflictCnt
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [NREG-1:0]   ONE_HOT0  = NREG'(1);

  logic              validA;
  logic              validB;
  logic [NREG-1:0]   decA;
  logic [NREG-1:0]   decB;
  logic              hit_same;

  logic [NREG-1:0]   enable_q,   enable_d;
  logic [NREG-1:0]   srcB_q,     srcB_d;
  logic              conflict_q, conflict_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  // Decode each channel; a write to the zero register never asserts a bit.
  always_comb begin
    validA   = wrA && (addrA != ZERO_ADDR);
    validB   = wrB && (addrB != ZERO_ADDR);
    decA     = validA ? (ONE_HOT0 << addrA) : '0;
    decB     = validB ? (ONE_HOT0 << addrB) : '0;
    // Both valid and equal address implies the same non-zero target.
    hit_same = validA && validB && (addrA == addrB);
  end

  // Next-state: stall freezes the pipeline register and drops the inputs;
  // the conflict pulse is cleared so a stalled collision is never counted.
  always_comb begin
    enable_d   = enable_q;
    srcB_d     = srcB_q;
    conflict_d = 1'b0;
    cnt_d      = cnt_q;
    if (!stall) begin
      // OR of the two one-hots collapses a collision into a single bit;
      // srcB marks it as channel B's write.
      enable_d   = decA | decB;
      srcB_d     = decB;
      conflict_d = hit_same;
      if (hit_same && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Pipeline register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q   <= '0;
      srcB_q     <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      enable_q   <= enable_d;
      srcB_q     <= srcB_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign enable      = enable_q;
  assign srcB        = srcB_q;
  assign conflict    = conflict_q;
  assign conflictCnt = cnt_q;

endmodule

// File: tb/tb_write_decoder_pipe.sv
module tb_write_decoder_pipe;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;

  typedef struct packed {
    logic [31:0]      en;
    logic [31:0]      src;
    logic             conf;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wrA = 1'b0, wrB = 1'b0, stall = 1'b0;
  logic [ADDR_W-1:0] addrA = '0, addrB = '0;
  logic [31:0]       enable, srcB;
  logic              conflict;
  logic [CNT_W-1:0]  conflictCnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  event sample_now;

  write_decoder_pipe #(.ADDR_W(ADDR_W), .ZERO_REG(31), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .wrA(wrA), .addrA(addrA), .wrB(wrB), .addrB(addrB), .stall(stall),
    .enable(enable), .srcB(srcB), .conflict(conflict), .conflictCnt(conflictCnt)
  );

  always #5 clk = ~clk;

  // Monitor: outputs sampled on the falling edge, or on demand for async reset.
  always begin
    exp_t e;
    @(negedge clk or sample_now);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (enable !== e.en) begin
        errors++;
        $display("FAIL enable: got %08h expected %08h", enable, e.en);
      end
      checks++;
      if (srcB !== e.src) begin
        errors++;
        $display("FAIL srcB: got %08h expected %08h", srcB, e.src);
      end
      checks++;
      if (conflict !== e.conf) begin
        errors++;
        $display("FAIL conflict: got %0b expected %0b", conflict, e.conf);
      end
      checks++;
      if (conflictCnt !== e.cnt) begin
        errors++;
        $display("FAIL conflictCnt: got %0d expected %0d", conflictCnt, e.cnt);
      end
    end
  end

  // One clock of stimulus followed by the hand-computed registered result.
  task automatic step(input logic rst, input logic a, input int aa,
                      input logic b, input int ab, input logic st,
                      input logic [31:0] en, input logic [31:0] src,
                      input logic conf, input int cnt);
    exp_t e;
    @(negedge clk);
    reset = rst;
    wrA   = a;  addrA = ADDR_W'(aa);
    wrB   = b;  addrB = ADDR_W'(ab);
    stall = st;
    @(posedge clk);
    #1;
    e.en = en; e.src = src; e.conf = conf; e.cnt = CNT_W'(cnt);
    sb.push_back(e);
  endtask

  // Reset pulse between edges; outputs must clear before any clock edge.
  task automatic reset_pulse();
    exp_t e;
    @(negedge clk);
    #1;
    stall = 1'b1;
    reset = 1'b0;
    #1;
    e = '0;
    sb.push_back(e);
    -> sample_now;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Held in reset with a live request: nothing may reach the outputs.
    step(0, 1, 3, 1, 3, 0, 32'h0, 32'h0, 0, 0);
    step(0, 1, 3, 1, 3, 0, 32'h0, 32'h0, 0, 0);
    step(0, 1, 3, 1, 3, 0, 32'h0, 32'h0, 0, 0);
    // Release: first edge decodes fresh inputs (same-register, B wins).
    step(1, 1, 3, 1, 3, 0, 32'h0000_0008, 32'h0000_0008, 1, 1);
    // Two distinct targets.
    step(1, 1, 5, 1, 9, 0, 32'h0000_0220, 32'h0000_0200, 0, 1);
    // Both to the zero register: no-op.
    step(1, 1, 31, 1, 31, 0, 32'h0, 32'h0, 0, 1);
    // A to zero register, B live.
    step(1, 1, 31, 1, 4, 0, 32'h0000_0010, 32'h0000_0010, 0, 1);
    // A only.
    step(1, 1, 2, 0, 0, 0, 32'h0000_0004, 32'h0, 0, 1);
    // Stall holds and discards inputs, including a would-be conflict.
    step(1, 0, 0, 1, 12, 1, 32'h0000_0004, 32'h0, 0, 1);
    step(1, 0, 0, 1, 12, 1, 32'h0000_0004, 32'h0, 0, 1);
    step(1, 1, 7, 1, 7, 1, 32'h0000_0004, 32'h0, 0, 1);
    // Unstall with no requests.
    step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1);
    // Load something, then async reset during stall clears everything.
    step(1, 1, 2, 1, 6, 0, 32'h0000_0044, 32'h0000_0040, 0, 1);
    reset_pulse();
    // First edge after reset decodes fresh inputs (not the stalled state).
    step(1, 0, 0, 1, 1, 0, 32'h0000_0002, 32'h0000_0002, 0, 0);
    // Repeated conflicts: counter saturates at 3.
    step(1, 1, 7, 1, 7, 0, 32'h0000_0080, 32'h0000_0080, 1, 1);
    step(1, 1, 7, 1, 7, 0, 32'h0000_0080, 32'h0000_0080, 1, 2);
    step(1, 1, 7, 1, 7, 0, 32'h0000_0080, 32'h0000_0080, 1, 3);
    step(1, 1, 7, 1, 7, 0, 32'h0000_0080, 32'h0000_0080, 1, 3);
    // Stall right after a conflict: outputs hold, conflict pulse drops.
    step(1, 1, 7, 1, 7, 1, 32'h0000_0080, 32'h0000_0080, 0, 3);
    // Zero-register collision does not count.
    step(1, 1, 31, 1, 31, 0, 32'h0, 32'h0, 0, 3);
    // No requests.
    step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 3);
    // Register 0 edge and the highest non-zero register.
    step(1, 1, 0, 1, 30, 0, 32'h4000_0001, 32'h4000_0000, 0, 3);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
